innings_controller: RTL and testbench

- Match-sequencing counterpart to the LED/ball-count block.
- Consumes the per-team legal-ball counts that block produces, together with the same play pulse and LFSR outcome.
- Accumulates runs and wickets, and drives teamSwitch, inningOver and gameOver back to it.
- Decides innings end, the switch to the chase, and the match result (T20: 120 balls, 10 wickets).

---
 rtl/cricket_pkg.sv | 34 +++
 rtl/innings_controller_if.sv | 32 +++
 rtl/ball_outcome_decoder.sv | 24 ++
 rtl/innings_controller.sv | 120 ++++++++++++
 tb/tb_innings_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cricket_pkg.sv
// Shared match-sequencing types: delivery outcome codes, FSM states,
// winner codes and T20 defaults.
package cricket_pkg;

    localparam int MAX_BALLS_DEF   = 120;
    localparam int MAX_WICKETS_DEF = 10;
    localparam int RUN_W_DEF       = 9;

    localparam logic [3:0] LFSR_WIDE   = 4'd13;
    localparam logic [3:0] LFSR_NOBALL = 4'd14;
    localparam logic [3:0] LFSR_WKT_A  = 4'd8;
    localparam logic [3:0] LFSR_WKT_B  = 4'd15;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1   = 2'b01;
    localparam logic [1:0] WIN_T2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    typedef enum logic [2:0] {
        INN1     = 3'd0,
        INN1_CHK = 3'd1,
        BREAK    = 3'd2,
        INN2     = 3'd3,
        INN2_CHK = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] runs;
        logic       wicket;
        logic       legal;
    } outcome_t;

endpackage

// File: rtl/innings_controller_if.sv
// Bundle between the ball counter / play source and the innings controller.
interface innings_controller_if #(
    parameter int RUN_W = 9
) ();
    logic             play;
    logic [3:0]       lfsr_out;
    logic [6:0]       team1Balls;
    logic [6:0]       team2Balls;
    logic             teamSwitch;
    logic             inningOver;
    logic             gameOver;
    logic [RUN_W-1:0] team1Runs;
    logic [RUN_W-1:0] team2Runs;
    logic [3:0]       team1Wkts;
    logic [3:0]       team2Wkts;
    logic [RUN_W:0]   target;
    logic [1:0]       winner;

    modport master (
        output play, lfsr_out, team1Balls, team2Balls,
        input  teamSwitch, inningOver, gameOver,
        input  team1Runs, team2Runs, team1Wkts, team2Wkts,
        input  target, winner
    );

    modport slave (
        input  play, lfsr_out, team1Balls, team2Balls,
        output teamSwitch, inningOver, gameOver,
        output team1Runs, team2Runs, team1Wkts, team2Wkts,
        output target, winner
    );
endinterface

// File: rtl/ball_outcome_decoder.sv
// Maps a 4-bit LFSR outcome to runs, wicket and legal-ball flags.
module ball_outcome_decoder
    import cricket_pkg::*;
(
    input  logic [3:0] i_code,
    output outcome_t   o_out
);
    always_comb begin
        o_out = '{runs: 3'd0, wicket: 1'b0, legal: 1'b1};
        case (i_code)
            4'd1, 4'd7:              o_out.runs = 3'd1;
            4'd2, 4'd10:             o_out.runs = 3'd2;
            4'd3:                    o_out.runs = 3'd3;
            4'd4, 4'd11:             o_out.runs = 3'd4;
            4'd6, 4'd12:             o_out.runs = 3'd6;
            LFSR_WKT_A, LFSR_WKT_B:  o_out.wicket = 1'b1;
            LFSR_WIDE, LFSR_NOBALL: begin
                o_out.runs  = 3'd1;
                o_out.legal = 1'b0;
            end
            default:                 o_out.runs = 3'd0;
        endcase
    end
endmodule

// File: rtl/innings_controller.sv
// Two-innings match sequencer: scores deliveries, detects innings end,
// runs the chase and declares the result.
module innings_controller
    import cricket_pkg::*;
#(
    parameter int MAX_BALLS   = MAX_BALLS_DEF,
    parameter int MAX_WICKETS = MAX_WICKETS_DEF,
    parameter int RUN_W       = RUN_W_DEF
) (
    input logic                 clk_fpga,
    input logic                 reset,
    innings_controller_if.slave bus
);
    localparam logic [6:0] B_MAX = 7'(MAX_BALLS);
    localparam logic [3:0] W_MAX = 4'(MAX_WICKETS);

    outcome_t         w_out;
    state_t           r_state;
    logic [RUN_W-1:0] r_t1_runs;
    logic [RUN_W-1:0] r_t2_runs;
    logic [3:0]       r_t1_wkts;
    logic [3:0]       r_t2_wkts;
    logic [RUN_W:0]   r_target;
    logic [1:0]       r_winner;
    logic             r_switch;
    logic             r_inn_over;
    logic             r_game_over;

    ball_outcome_decoder u_dec (
        .i_code (bus.lfsr_out),
        .o_out  (w_out)
    );

    function automatic logic [RUN_W-1:0] sat_add(
        input logic [RUN_W-1:0] a,
        input logic [2:0]       b
    );
        logic [RUN_W:0] s;
        s = {1'b0, a} + {{(RUN_W-2){1'b0}}, b};
        return s[RUN_W] ? '1 : s[RUN_W-1:0];
    endfunction

    function automatic logic [3:0] wkt_add(
        input logic [3:0] w,
        input logic       hit
    );
        return (hit && w != 4'hF) ? w + 4'd1 : w;
    endfunction

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            r_state     <= INN1;
            r_t1_runs   <= '0;
            r_t2_runs   <= '0;
            r_t1_wkts   <= '0;
            r_t2_wkts   <= '0;
            r_target    <= '0;
            r_winner    <= WIN_NONE;
            r_switch    <= 1'b0;
            r_inn_over  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            unique case (r_state)
                INN1: if (bus.play) begin
                    r_t1_runs <= sat_add(r_t1_runs, w_out.runs);
                    r_t1_wkts <= wkt_add(r_t1_wkts, w_out.wicket);
                    r_state   <= INN1_CHK;
                end
                INN1_CHK: begin
                    if (bus.team1Balls == B_MAX || r_t1_wkts == W_MAX) begin
                        r_inn_over <= 1'b1;
                        r_target   <= {1'b0, r_t1_runs} + (RUN_W+1)'(1);
                        r_state    <= BREAK;
                    end else begin
                        r_state <= INN1;
                    end
                end
                // The start-of-chase press only flips sides; it is not scored.
                BREAK: if (bus.play) begin
                    r_switch   <= 1'b1;
                    r_inn_over <= 1'b0;
                    r_state    <= INN2;
                end
                INN2: if (bus.play) begin
                    r_t2_runs <= sat_add(r_t2_runs, w_out.runs);
                    r_t2_wkts <= wkt_add(r_t2_wkts, w_out.wicket);
                    r_state   <= INN2_CHK;
                end
                INN2_CHK: begin
                    if (r_t2_runs > r_t1_runs) begin
                        r_winner    <= WIN_T2;
                        r_inn_over  <= 1'b1;
                        r_game_over <= 1'b1;
                        r_state     <= DONE;
                    end else if (bus.team2Balls == B_MAX ||
                                 r_t2_wkts == W_MAX) begin
                        r_winner    <= (r_t1_runs > r_t2_runs) ? WIN_T1 : WIN_TIE;
                        r_inn_over  <= 1'b1;
                        r_game_over <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= INN2;
                    end
                end
                DONE: r_state <= DONE;
                default: r_state <= INN1;
            endcase
        end
    end

    assign bus.teamSwitch = r_switch;
    assign bus.inningOver = r_inn_over;
    assign bus.gameOver   = r_game_over;
    assign bus.team1Runs  = r_t1_runs;
    assign bus.team2Runs  = r_t2_runs;
    assign bus.team1Wkts  = r_t1_wkts;
    assign bus.team2Wkts  = r_t2_wkts;
    assign bus.target     = r_target;
    assign bus.winner     = r_winner;
endmodule

// File: tb/tb_innings_controller.sv
// Directed bench: models the ball counter and walks both innings,
// chase wins, tie/loss, reset and run saturation.
module tb_innings_controller;
    logic clk_fpga = 1'b0;
    logic reset    = 1'b1;
    int   n_vec    = 0;
    int   n_miss   = 0;
    logic r_prev_play   = 1'b0;
    logic r_spacing_err = 1'b0;
    logic [6:0] b1, b2, c1, c2;

    innings_controller_if #(.RUN_W(9)) bus ();
    innings_controller_if #(.RUN_W(5)) bus5 ();

    innings_controller #(.RUN_W(9)) dut (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .bus      (bus)
    );

    innings_controller #(.RUN_W(5)) dut5 (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .bus      (bus5)
    );

    always #5 clk_fpga = ~clk_fpga;

    function automatic logic legal(input logic [3:0] code);
        return !(code == 4'd13 || code == 4'd14);
    endfunction

    // Ball counter model: counts legal deliveries of the batting side while live.
    always @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            b1 <= '0; b2 <= '0; c1 <= '0; c2 <= '0;
        end else begin
            if (bus.play && legal(bus.lfsr_out) && !bus.inningOver && !bus.gameOver) begin
                if (bus.teamSwitch) b2 <= b2 + 7'd1;
                else                b1 <= b1 + 7'd1;
            end
            if (bus5.play && legal(bus5.lfsr_out) && !bus5.inningOver && !bus5.gameOver) begin
                if (bus5.teamSwitch) c2 <= c2 + 7'd1;
                else                 c1 <= c1 + 7'd1;
            end
        end
    end

    assign bus.team1Balls  = b1;
    assign bus.team2Balls  = b2;
    assign bus5.team1Balls = c1;
    assign bus5.team2Balls = c2;

    // Back-to-back play pulses break the upstream contract.
    always @(posedge clk_fpga) begin
        if (bus.play && r_prev_play) r_spacing_err <= 1'b1;
        r_prev_play <= bus.play;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic deliver(input int d, input logic [3:0] code);
        @(negedge clk_fpga);
        if (d == 0) begin bus.play = 1'b1; bus.lfsr_out = code; end
        else        begin bus5.play = 1'b1; bus5.lfsr_out = code; end
        @(negedge clk_fpga);
        bus.play  = 1'b0;
        bus5.play = 1'b0;
        @(negedge clk_fpga);
    endtask

    task automatic do_reset();
        @(negedge clk_fpga);
        reset = 1'b1;
        @(negedge clk_fpga);
        reset = 1'b0;
    endtask

    initial begin
        bus.play = 1'b0;  bus.lfsr_out = '0;
        bus5.play = 1'b0; bus5.lfsr_out = '0;
        repeat (2) @(negedge clk_fpga);
        reset = 1'b0;
        chk("rst_runs1", 32'(bus.team1Runs), 0);
        chk("rst_switch", 32'(bus.teamSwitch), 0);
        chk("rst_inn_over", 32'(bus.inningOver), 0);
        chk("rst_game_over", 32'(bus.gameOver), 0);
        chk("rst_target", 32'(bus.target), 0);
        chk("rst_winner", 32'(bus.winner), 0);

        // Team 1 reaches 87 all out, then reset lands mid-chase.
        repeat (14) deliver(0, 4'd6);
        deliver(0, 4'd3);
        repeat (10) deliver(0, 4'd8);
        chk("t87_runs", 32'(bus.team1Runs), 87);
        chk("t87_target", 32'(bus.target), 88);
        deliver(0, 4'd1);
        deliver(0, 4'd2);
        chk("t87_inn2_runs", 32'(bus.team2Runs), 2);
        #3 reset = 1'b1;
        #1;
        chk("async_runs1", 32'(bus.team1Runs), 0);
        chk("async_runs2", 32'(bus.team2Runs), 0);
        chk("async_switch", 32'(bus.teamSwitch), 0);
        chk("async_target", 32'(bus.target), 0);
        chk("async_wkts1", 32'(bus.team1Wkts), 0);
        @(negedge clk_fpga);
        reset = 1'b0;
        deliver(0, 4'd1);
        chk("post_rst_runs1", 32'(bus.team1Runs), 1);
        chk("post_rst_switch", 32'(bus.teamSwitch), 0);

        // 120 singles end the first innings on the ball limit.
        do_reset();
        repeat (119) deliver(0, 4'd1);
        @(negedge clk_fpga);
        bus.play = 1'b1; bus.lfsr_out = 4'd1;
        @(negedge clk_fpga);
        bus.play = 1'b0;
        chk("b120_chk_cycle_over", 32'(bus.inningOver), 0);
        chk("b120_runs", 32'(bus.team1Runs), 120);
        @(negedge clk_fpga);
        chk("b120_inn_over", 32'(bus.inningOver), 1);
        chk("b120_target", 32'(bus.target), 121);
        deliver(0, 4'd4);
        chk("start_switch", 32'(bus.teamSwitch), 1);
        chk("start_inn_over", 32'(bus.inningOver), 0);
        chk("start_runs2", 32'(bus.team2Runs), 0);

        // Ten wickets for nothing.
        do_reset();
        repeat (10) deliver(0, 4'd8);
        chk("w10_wkts", 32'(bus.team1Wkts), 10);
        chk("w10_runs", 32'(bus.team1Runs), 0);
        chk("w10_inn_over", 32'(bus.inningOver), 1);
        chk("w10_balls", 32'(b1), 10);
        chk("w10_target", 32'(bus.target), 1);

        // Target 7 chased with a six then a wide.
        do_reset();
        deliver(0, 4'd6);
        repeat (10) deliver(0, 4'd15);
        chk("t7_target", 32'(bus.target), 7);
        deliver(0, 4'd0);
        deliver(0, 4'd6);
        chk("t7_six_game_over", 32'(bus.gameOver), 0);
        deliver(0, 4'd13);
        chk("t7_runs2", 32'(bus.team2Runs), 7);
        chk("t7_game_over", 32'(bus.gameOver), 1);
        chk("t7_inn_over", 32'(bus.inningOver), 1);
        chk("t7_winner", 32'(bus.winner), 2);
        chk("t7_balls2", 32'(b2), 1);
        deliver(0, 4'd4);
        chk("t7_frozen_runs2", 32'(bus.team2Runs), 7);
        chk("t7_frozen_winner", 32'(bus.winner), 2);

        // Tie on 30 after full overs, then a one-run loss.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            repeat (30) deliver(0, 4'd1);
            repeat (90) deliver(0, 4'd0);
            chk("tie_target", 32'(bus.target), 31);
            deliver(0, 4'd0);
            repeat (30 - k) deliver(0, 4'd7);
            repeat (89 + k) deliver(0, 4'd5);
            chk("tie_pre_game_over", 32'(bus.gameOver), 0);
            deliver(0, 4'd9);
            chk("tie_game_over", 32'(bus.gameOver), 1);
            chk("tie_winner", 32'(bus.winner), (k == 0) ? 3 : 1);
        end

        // Wides and no-balls score but are not legal balls.
        do_reset();
        deliver(0, 4'd13);
        deliver(0, 4'd14);
        deliver(0, 4'd13);
        chk("extras_runs", 32'(bus.team1Runs), 3);
        chk("extras_inn_over", 32'(bus.inningOver), 0);

        // Saturation on the narrow instance.
        deliver(1, 4'd13);
        deliver(1, 4'd14);
        chk("sat_extras_runs", 32'(bus5.team1Runs), 2);
        chk("sat_extras_balls", 32'(c1), 0);
        repeat (5) deliver(1, 4'd6);
        chk("sat_runs_5", 32'(bus5.team1Runs), 31);
        repeat (5) deliver(1, 4'd12);
        chk("sat_runs_10", 32'(bus5.team1Runs), 31);

        chk("play_spacing", 32'(r_spacing_err), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
